// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared constants for the column-serial InvMixColumns engine: FSM encoding,
// geometry, GF(2^8) coefficients and byte-index helpers.
package inv_mix_columns_seq_pkg;

  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;
  localparam int STATE_W  = COL_W * NUM_COLS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Row 0 of each circulant matrix; row r uses element (j - r) mod 4 for input byte j.
  localparam logic [7:0] INV_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
  localparam logic [7:0] FWD_COEF [4] = '{8'h02, 8'h03, 8'h01, 8'h01};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // MSB position of byte s(r,c) inside the 128-bit state.
  function automatic int byte_msb(input int r, input int c);
    return STATE_W - 1 - 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bundle for inv_mix_columns_seq; the fwd mode bit exists only
// when IMC_FWD_MODE_EN is defined.
interface inv_mix_columns_seq_if;
  import inv_mix_columns_seq_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_state;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_state;
  logic               busy;
`ifdef IMC_FWD_MODE_EN
  logic               fwd;
`endif

  modport master (
    output in_valid, in_state, out_ready,
`ifdef IMC_FWD_MODE_EN
    output fwd,
`endif
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, out_ready,
`ifdef IMC_FWD_MODE_EN
    input  fwd,
`endif
    output in_ready, out_valid, out_state, busy
  );

endinterface

// File: rtl/inv_mix_columns_seq_imc_column.sv
// Single-column (Inv)MixColumns transform built from constant GF(2^8) multipliers.
// IMC_FWD_MODE_EN adds the forward coefficient set and the i_fwd select.
module gf_mul_const
  import inv_mix_columns_seq_pkg::*;
#(
  parameter logic [7:0] COEF = 8'h01
) (
  input  logic [7:0] i_a,
  output logic [7:0] o_p
);
  // All AES coefficients fit in 4 bits, so x, 2x, 4x, 8x cover every product.
  logic [7:0] w_pow [4];

  assign w_pow[0] = i_a;
  assign w_pow[1] = xtime(w_pow[0]);
  assign w_pow[2] = xtime(w_pow[1]);
  assign w_pow[3] = xtime(w_pow[2]);

  always_comb begin
    o_p = 8'h00;
    for (int k = 0; k < 4; k++) begin
      if (COEF[k]) o_p ^= w_pow[k];
    end
  end
endmodule

module imc_column
  import inv_mix_columns_seq_pkg::*;
(
  input  logic [COL_W-1:0] i_col,
`ifdef IMC_FWD_MODE_EN
  input  logic             i_fwd,
`endif
  output logic [COL_W-1:0] o_col
);
  logic [7:0] w_a   [4];
  logic [7:0] w_inv [4][4];
`ifdef IMC_FWD_MODE_EN
  logic [7:0] w_fwd [4][4];
`endif

  for (genvar j = 0; j < 4; j++) begin : g_in
    assign w_a[j] = i_col[COL_W-1-8*j -: 8];
    for (genvar k = 0; k < 4; k++) begin : g_coef
      gf_mul_const #(.COEF(INV_COEF[k])) u_inv (.i_a(w_a[j]), .o_p(w_inv[j][k]));
`ifdef IMC_FWD_MODE_EN
      gf_mul_const #(.COEF(FWD_COEF[k])) u_fwd (.i_a(w_a[j]), .o_p(w_fwd[j][k]));
`endif
    end
  end

  always_comb begin
    o_col = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
`ifdef IMC_FWD_MODE_EN
        o_col[COL_W-1-8*i -: 8] ^= i_fwd ? w_fwd[j][(j-i) & 3] : w_inv[j][(j-i) & 3];
`else
        o_col[COL_W-1-8*i -: 8] ^= w_inv[j][(j-i) & 3];
`endif
      end
    end
  end
endmodule

// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns: one shared column unit, one column per cycle.
// Optional IMC_FWD_MODE_EN latches a fwd bit on accept to run forward MixColumns.
module inv_mix_columns_seq #(
  parameter int NUM_COLS = inv_mix_columns_seq_pkg::NUM_COLS,
  parameter int COL_W    = inv_mix_columns_seq_pkg::COL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inv_mix_columns_seq_if.slave bus
);
  import inv_mix_columns_seq_pkg::*;

  logic [1:0]                r_fsm;
  logic [1:0]                r_cnt;
  logic [NUM_COLS*COL_W-1:0] r_state;
  logic [COL_W-1:0]          w_col_in;
  logic [COL_W-1:0]          w_col_out;
`ifdef IMC_FWD_MODE_EN
  logic                      r_fwd;
`endif

  // Column 0 is the most significant word of the state.
  assign w_col_in = r_state[(NUM_COLS-1-int'(r_cnt))*COL_W +: COL_W];

  imc_column u_col (
    .i_col (w_col_in),
`ifdef IMC_FWD_MODE_EN
    .i_fwd (r_fwd),
`endif
    .o_col (w_col_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_state <= '0;
`ifdef IMC_FWD_MODE_EN
      r_fwd   <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_state <= bus.in_state;
            r_cnt   <= 2'd0;
            r_fsm   <= ST_BUSY;
`ifdef IMC_FWD_MODE_EN
            r_fwd   <= bus.fwd;
`endif
          end
        end
        ST_BUSY: begin
          r_state[(NUM_COLS-1-int'(r_cnt))*COL_W +: COL_W] <= w_col_out;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'(NUM_COLS - 1)) r_fsm <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) r_fsm <= ST_IDLE;
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_fsm == ST_IDLE);
  assign bus.out_valid = (r_fsm == ST_DONE);
  assign bus.busy      = (r_fsm != ST_IDLE);
  assign bus.out_state = r_state;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Randomized self-checking bench for inv_mix_columns_seq against a matrix-level
// GF(2^8) reference model; covers latency, back-pressure, back-to-back and reset.
module tb_inv_mix_columns_seq;

  localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  // Accept-to-accept: four column cycles, one DONE cycle, one mandatory IDLE cycle.
  localparam int ACC_GAP = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc [$];
  logic [127:0] out_q [$];

  inv_mix_columns_seq_if bus ();

  inv_mix_columns_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
    if (rst_n && bus.out_valid && bus.out_ready) out_q.push_back(bus.out_state);
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit fwd);
    logic [7:0] inv_m [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                 '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    logic [7:0] fwd_m [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
                                 '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    logic [127:0] r = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(fwd ? fwd_m[row][k] : inv_m[row][k], s[127-8*(4*c+k) -: 8]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_txn(input string tag, input logic [127:0] s, input bit f,
                        input logic [127:0] exp, input int stall);
    int t;
    int lat;
    bit bad;
    logic [127:0] held;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    check_eq({tag, "_rdy"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_state = s;
`ifdef IMC_FWD_MODE_EN
    bus.fwd = f;
`endif
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_state = rnd128();
`ifdef IMC_FWD_MODE_EN
    bus.fwd = ~f;
`endif
    lat = 0;
    bad = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
      @(posedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, lat, 4);
    check_eq({tag, "_busyphase"}, bad, 1'b0);
    check_eq({tag, "_data"}, bus.out_state, exp);
    check_eq({tag, "_done_busy"}, {bus.busy, bus.in_ready}, 2'b10);
    held = bus.out_state;
    bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.out_state !== held || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    if (stall > 0) check_eq({tag, "_hold"}, bad, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_idle"}, {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int base_a;
    int base_o;
    bit f;
    logic [127:0] s;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.out_ready = 1'b1;
`ifdef IMC_FWD_MODE_EN
    bus.fwd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    check_eq("rst_state", bus.out_state, '0);
    check_eq("rst_nox", $isunknown({bus.in_ready, bus.out_valid, bus.busy, bus.out_state}), 1'b0);

    do_txn("single", V1, 1'b0, E1, 0);
    do_txn("bp", V1, 1'b0, E1, 10);

    // Back-to-back with in_valid held through BUSY/DONE and garbage on in_state.
    base_a = acc_cyc.size();
    base_o = out_q.size();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = V2;
    t = 0;
    while (acc_cyc.size() == base_a && t < 20) begin @(posedge clk); #1; t++; end
    bus.in_state = rnd128();
    repeat (3) @(posedge clk);
    #1 bus.in_state = V1;
    t = 0;
    while (acc_cyc.size() < base_a + 2 && t < 20) begin @(posedge clk); #1; t++; end
    bus.in_valid = 1'b0;
    t = 0;
    while (out_q.size() < base_o + 2 && t < 30) begin @(posedge clk); #1; t++; end
    check_eq("b2b_acc_cnt", acc_cyc.size() - base_a, 2);
    check_eq("b2b_out_cnt", out_q.size() - base_o, 2);
    if (acc_cyc.size() >= base_a + 2)
      check_eq("b2b_gap", acc_cyc[base_a+1] - acc_cyc[base_a], ACC_GAP);
    if (out_q.size() >= base_o + 2) begin
      check_eq("b2b_out0", out_q[base_o], E2);
      check_eq("b2b_out1", out_q[base_o+1], E1);
    end

    // Asynchronous reset during cycle 2 of BUSY.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_state = rnd128();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check_eq("mid_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    check_eq("mid_rst_state", bus.out_state, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rdy", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    s = rnd128();
    do_txn("post_rst", s, 1'b0, ref_mix(s, 1'b0), 0);

`ifdef IMC_FWD_MODE_EN
    do_txn("fwd", E1, 1'b1, V1, 0);
`endif

    for (int n = 0; n < 8; n++) begin
      s = rnd128();
      f = 1'b0;
`ifdef IMC_FWD_MODE_EN
      f = 1'($urandom_range(0, 1));
`endif
      do_txn("rnd", s, f, ref_mix(s, f), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
